// File: rtl/dilated_tap_cache.sv
// Circular activation cache between two conv1d layers: stores each 4-channel
// sample and presents the dilated causal taps at offsets 3D, 2D, D and 0.
module dilated_tap_cache #(
    parameter int W        = 16,
    parameter int DILATION = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_v,
    input  logic signed [W-1:0] in_data [0:3],
    output logic signed [W-1:0] a0 [0:3],
    output logic signed [W-1:0] a1 [0:3],
    output logic signed [W-1:0] a2 [0:3],
    output logic signed [W-1:0] a3 [0:3],
    output logic                out_v,
    output logic                busy,
    output logic                overflow
);
    localparam int DEPTH = 3 * DILATION + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int SW    = 4 * W;

    typedef enum logic [1:0] {IDLE, WRITE, READ, VALID} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] in_reg;
    logic [SW-1:0] rd_data_p0;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] base;
    logic [AW-1:0] off;
    logic [AW-1:0] rd_addr;
    logic [FW-1:0] fill;
    logic [1:0]    idx;
    logic [1:0]    rd_lane_p0;
    logic          rd_v_p0;
    logic          rd_zero_p0;
    logic          accept;

    function automatic logic [AW-1:0] tap_offset(input logic [1:0] i);
        case (i)
            2'd0:    tap_offset = AW'(3 * DILATION);
            2'd1:    tap_offset = AW'(2 * DILATION);
            2'd2:    tap_offset = AW'(DILATION);
            default: tap_offset = '0;
        endcase
    endfunction

    // True result is always below DEPTH, so modular AW-bit arithmetic is exact.
    function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] b, input logic [AW-1:0] o);
        wrap_sub = (b >= o) ? (b - o) : (b + AW'(DEPTH) - o);
    endfunction

    assign busy    = (state == WRITE) || (state == READ);
    assign accept  = in_v && !busy;
    assign off     = tap_offset(idx);
    assign rd_addr = wrap_sub(base, off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_v) state_next = WRITE;
            WRITE:   state_next = READ;
            READ:    if (idx == 2'd3) state_next = VALID;
            VALID:   if (in_v) state_next = WRITE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            base       <= '0;
            fill       <= '0;
            idx        <= '0;
            out_v      <= 1'b0;
            overflow   <= 1'b0;
            rd_v_p0    <= 1'b0;
            rd_lane_p0 <= '0;
            rd_zero_p0 <= 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                a0[ch] <= '0;
                a1[ch] <= '0;
                a2[ch] <= '0;
                a3[ch] <= '0;
            end
        end else begin
            if (in_v && busy) overflow <= 1'b1;
            rd_v_p0 <= 1'b0;

            if (state == WRITE) begin
                base   <= wr_ptr;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
                out_v  <= 1'b0;
                idx    <= '0;
            end

            // Read issue: lane tag and causal-padding flag travel with the read
            if (state == READ) begin
                idx        <= idx + 1'b1;
                rd_v_p0    <= 1'b1;
                rd_lane_p0 <= idx;
                rd_zero_p0 <= (FW'(off) >= fill);
            end

            // Capture: one tap per cycle, newest tap last raises out_v
            if (rd_v_p0) begin
                for (int ch = 0; ch < 4; ch++) begin
                    case (rd_lane_p0)
                        2'd0:    a0[ch] <= rd_zero_p0 ? '0 : rd_data_p0[ch*W +: W];
                        2'd1:    a1[ch] <= rd_zero_p0 ? '0 : rd_data_p0[ch*W +: W];
                        2'd2:    a2[ch] <= rd_zero_p0 ? '0 : rd_data_p0[ch*W +: W];
                        default: a3[ch] <= rd_zero_p0 ? '0 : rd_data_p0[ch*W +: W];
                    endcase
                end
                if (rd_lane_p0 == 2'd3) out_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int ch = 0; ch < 4; ch++) in_reg[ch*W +: W] <= in_data[ch];
        end
        if (state == WRITE) mem[wr_ptr] <= in_reg;
        if (state == READ)  rd_data_p0  <= mem[rd_addr];
    end
endmodule

// File: tb/tb_dilated_tap_cache.sv
// Scoreboard bench for dilated_tap_cache: D=1 and D=2 instances, history-based
// tap model, latency checked against the strobe edge.
module tb_dilated_tap_cache;
    localparam int W  = 16;
    localparam int SW = 4 * W;
    localparam int TW = 16 * W;

    typedef struct packed {
        logic [TW-1:0] taps;
        logic [31:0]   when_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_v1 = 1'b0;
    logic in_v2 = 1'b0;
    logic signed [W-1:0] din1 [0:3];
    logic signed [W-1:0] din2 [0:3];
    logic signed [W-1:0] a0_1 [0:3];
    logic signed [W-1:0] a1_1 [0:3];
    logic signed [W-1:0] a2_1 [0:3];
    logic signed [W-1:0] a3_1 [0:3];
    logic signed [W-1:0] a0_2 [0:3];
    logic signed [W-1:0] a1_2 [0:3];
    logic signed [W-1:0] a2_2 [0:3];
    logic signed [W-1:0] a3_2 [0:3];
    logic out_v1, busy1, ovf1;
    logic out_v2, busy2, ovf2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [SW-1:0] h1[$];
    logic [SW-1:0] h2[$];
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;
    exp_t e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dilated_tap_cache #(.W(W), .DILATION(1)) u_d1 (
        .clk(clk), .rst(rst), .in_v(in_v1), .in_data(din1),
        .a0(a0_1), .a1(a1_1), .a2(a2_1), .a3(a3_1),
        .out_v(out_v1), .busy(busy1), .overflow(ovf1)
    );

    dilated_tap_cache #(.W(W), .DILATION(2)) u_d2 (
        .clk(clk), .rst(rst), .in_v(in_v2), .in_data(din2),
        .a0(a0_2), .a1(a1_2), .a2(a2_2), .a3(a3_2),
        .out_v(out_v2), .busy(busy2), .overflow(ovf2)
    );

    task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] taps1();
        logic [TW-1:0] r;
        for (int ch = 0; ch < 4; ch++) begin
            r[(0 + ch)*W +: W]  = a0_1[ch];
            r[(4 + ch)*W +: W]  = a1_1[ch];
            r[(8 + ch)*W +: W]  = a2_1[ch];
            r[(12 + ch)*W +: W] = a3_1[ch];
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] taps2();
        logic [TW-1:0] r;
        for (int ch = 0; ch < 4; ch++) begin
            r[(0 + ch)*W +: W]  = a0_2[ch];
            r[(4 + ch)*W +: W]  = a1_2[ch];
            r[(8 + ch)*W +: W]  = a2_2[ch];
            r[(12 + ch)*W +: W] = a3_2[ch];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] lanes(input int v);
        logic [W-1:0] x;
        x = W'(v);
        return {x, x, x, x};
    endfunction

    function automatic logic [TW-1:0] uni(input int v0, input int v1, input int v2, input int v3);
        return {lanes(v3), lanes(v2), lanes(v1), lanes(v0)};
    endfunction

    task automatic push_exp(input int dut, input logic [SW-1:0] s);
        logic [SW-1:0] h[$];
        logic [SW-1:0] smp;
        exp_t e;
        int n, k, d;
        if (dut == 1) begin h1.push_back(s); h = h1; d = 1; end
        else          begin h2.push_back(s); h = h2; d = 2; end
        n = h.size();
        e.taps = '0;
        for (int t = 0; t < 4; t++) begin
            k = n - 1 - (3 - t) * d;
            if (k >= 0) begin
                smp = h[k];
                e.taps[t*SW +: SW] = smp;
            end
        end
        e.when_c = 32'(cyc + 7);
        if (dut == 1) q1.push_back(e);
        else          q2.push_back(e);
    endtask

    task automatic strobe(input int dut, input logic [SW-1:0] s, input bit acc);
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            if (dut == 1) din1[ch] = s[ch*W +: W];
            else          din2[ch] = s[ch*W +: W];
        end
        if (dut == 1) in_v1 = 1'b1;
        else          in_v2 = 1'b1;
        if (acc) push_exp(dut, s);
        @(negedge clk);
        in_v1 = 1'b0;
        in_v2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q1.delete(); q2.delete(); h1.delete(); h2.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_v1 && !pv1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL d1_unexpected_out_v: got out_v rise required none pending");
            end else begin
                e1 = q1.pop_front();
                chk("d1_taps", taps1(), e1.taps);
                chk("d1_latency", TW'(cyc), TW'(e1.when_c));
            end
        end
        pv1 = out_v1;
    end

    always @(negedge clk) begin
        if (!rst && out_v2 && !pv2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL d2_unexpected_out_v: got out_v rise required none pending");
            end else begin
                e2 = q2.pop_front();
                chk("d2_taps", taps2(), e2.taps);
                chk("d2_latency", TW'(cyc), TW'(e2.when_c));
            end
        end
        pv2 = out_v2;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] x;
        for (int ch = 0; ch < 4; ch++) begin
            din1[ch] = '0;
            din2[ch] = '0;
        end
        rst = 1'b1;
        idle(3);
        chk("reset_out_v1", TW'(out_v1), '0);
        chk("reset_ovf1",   TW'(ovf1), '0);
        chk("reset_busy1",  TW'(busy1), '0);
        chk("reset_taps1",  taps1(), '0);
        chk("reset_out_v2", TW'(out_v2), '0);
        chk("reset_taps2",  taps2(), '0);
        rst = 1'b0;

        // Single sample, distinct lanes: only the newest tap is populated
        strobe(1, {16'h7FFF, 16'h0001, 16'hF000, 16'h1000}, 1'b1);
        idle(8);
        x = '0;
        x[TW-1 -: SW] = {16'h7FFF, 16'h0001, 16'hF000, 16'h1000};
        chk("t1_taps", taps1(), x);
        chk("t1_out_v_held", TW'(out_v1), TW'(1));

        do_reset();
        for (int k = 1; k <= 5; k++) begin
            strobe(1, lanes(k), 1'b1);
            idle(6);
            if (k == 2) chk("t2_after2", taps1(), uni(0, 0, 1, 2));
        end
        chk("t2_after5", taps1(), uni(2, 3, 4, 5));

        do_reset();
        for (int k = 1; k <= 9; k++) begin
            strobe(2, lanes(k), 1'b1);
            idle(6);
            if (k == 3) chk("d2_after3", taps2(), uni(0, 0, 1, 3));
        end
        chk("d2_after9", taps2(), uni(3, 5, 7, 9));
        chk("d2_wr_ptr", TW'(u_d2.wr_ptr), TW'(2));
        chk("d2_fill", TW'(u_d2.fill), TW'(7));

        // Strobe 3 cycles after the first is dropped; one 6 cycles after is taken
        do_reset();
        strobe(1, lanes(11), 1'b1);
        idle(1);
        strobe(1, lanes(22), 1'b0);
        chk("ovf_set", TW'(ovf1), TW'(1));
        idle(1);
        strobe(1, lanes(33), 1'b1);
        idle(8);
        chk("ovf_sticky", TW'(ovf1), TW'(1));
        chk("ovf_taps", taps1(), uni(0, 0, 11, 33));

        do_reset();
        chk("ovf_cleared", TW'(ovf1), '0);
        for (int k = 1; k <= 3; k++) begin
            strobe(1, lanes(k), 1'b1);
            idle(6);
        end
        strobe(1, lanes(4), 1'b1);
        idle(3);
        rst = 1'b1;
        q1.delete(); h1.delete();
        #1;
        chk("midrst_out_v", TW'(out_v1), '0);
        chk("midrst_taps", taps1(), '0);
        chk("midrst_busy", TW'(busy1), '0);
        @(negedge clk);
        rst = 1'b0;
        strobe(1, lanes(16'h0042), 1'b1);
        idle(8);
        chk("midrst_next", taps1(), uni(0, 0, 0, 16'h0042));

        do_reset();
        for (int k = 1; k <= 20; k++) begin
            strobe(1, lanes(k), 1'b1);
            idle(4);
        end
        idle(8);
        chk("b2b_no_ovf", TW'(ovf1), '0);
        chk("b2b_last", taps1(), uni(17, 18, 19, 20));

        for (int i = 0; i < 50 && (q1.size() + q2.size()) != 0; i++) @(negedge clk);
        chk("scoreboard_drained", TW'(q1.size() + q2.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
